// File: rtl/smem_token_store.sv
// Token store: curr array with a stalled 1-cycle read port, mem array drained in index order via valid/ready.
// Optional macro TOKEN_STORE_BYPASS_EN: write-first forwarding on a curr read/write collision.
module smem_token_store #(
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              stall_i,
   input  logic              store_valid_curr_i,
   input  logic [63:0]       curr_x_0_i,
   input  logic [63:0]       curr_x_1_i,
   input  logic [63:0]       curr_x_2_i,
   input  logic [63:0]       curr_x_info_i,
   input  logic [ADDR_W-1:0] curr_x_addr_i,
   input  logic              store_valid_mem_i,
   input  logic [63:0]       mem_x_0_i,
   input  logic [63:0]       mem_x_1_i,
   input  logic [63:0]       mem_x_2_i,
   input  logic [63:0]       mem_x_info_i,
   input  logic [ADDR_W-1:0] mem_x_addr_i,
   input  logic [ADDR_W-1:0] current_rd_addr_i,
   output logic [255:0]      rd_data_o,
   input  logic              drain_start_i,
   input  logic [ADDR_W:0]   drain_len_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [255:0]      out_data_o,
   output logic [ADDR_W-1:0] out_idx_o,
   output logic              drain_busy_o,
   output logic              drain_done_o
);

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_e;

   logic [255:0]      curr_q [DEPTH];
   logic [255:0]      mem_q  [DEPTH];
   logic [255:0]      curr_wdata;
   logic [255:0]      mem_wdata;
   logic [255:0]      rd_data_d;
   logic [255:0]      rd_data_q;

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W:0]   len_q;
   logic [255:0]      out_data_q;
   logic [ADDR_W-1:0] out_idx_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              is_last;

   assign curr_wdata = {curr_x_info_i, curr_x_2_i, curr_x_1_i, curr_x_0_i};
   assign mem_wdata  = {mem_x_info_i, mem_x_2_i, mem_x_1_i, mem_x_0_i};

   // Arrays carry no reset so contents survive a mid-drain reset.
   always_ff @(posedge clk_i) begin
      if (store_valid_curr_i) curr_q[curr_x_addr_i] <= curr_wdata;
      if (store_valid_mem_i)  mem_q[mem_x_addr_i]   <= mem_wdata;
   end

`ifdef TOKEN_STORE_BYPASS_EN
   assign rd_data_d = (store_valid_curr_i && (curr_x_addr_i == current_rd_addr_i))
                      ? curr_wdata : curr_q[current_rd_addr_i];
`else
   assign rd_data_d = curr_q[current_rd_addr_i];
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       rd_data_q <= '0;
      else if (!stall_i) rd_data_q <= rd_data_d;
   end

   // len_q is never zero outside IDLE/DONE, so len_q-1 cannot underflow here.
   assign is_last = ({1'b0, idx_q} == (len_q - {{ADDR_W{1'b0}}, 1'b1}));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (drain_start_i) begin
                  len_q  <= drain_len_i;
                  idx_q  <= '0;
                  busy_q <= 1'b1;
                  if (drain_len_i == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= FETCH;
                  end
               end
            end
            FETCH: begin
               out_data_q  <= mem_q[idx_q];
               out_idx_q   <= idx_q;
               out_valid_q <= 1'b1;
               state_q     <= PRESENT;
            end
            PRESENT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  if (is_last) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + ADDR_W'(1);
                     state_q <= FETCH;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_data_o    = rd_data_q;
   assign out_data_o   = out_data_q;
   assign out_idx_o    = out_idx_q;
   assign out_valid_o  = out_valid_q;
   assign drain_busy_o = busy_q;
   assign drain_done_o = done_q;

endmodule

// File: tb/tb_smem_token_store.sv
// Directed self-checking bench for smem_token_store: curr read/stall/collision, mem drain, reset.
module tb_smem_token_store;
   localparam int ADDR_W = 7;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk, rst_n, stall;
   logic store_valid_curr, store_valid_mem;
   logic [63:0] curr_x_0, curr_x_1, curr_x_2, curr_x_info;
   logic [63:0] mem_x_0, mem_x_1, mem_x_2, mem_x_info;
   logic [ADDR_W-1:0] curr_x_addr, mem_x_addr, current_rd_addr;
   logic [255:0] rd_data, out_data;
   logic drain_start, out_valid, out_ready, drain_busy, drain_done;
   logic [ADDR_W:0] drain_len;
   logic [ADDR_W-1:0] out_idx;

   int nchk = 0;
   int nfail = 0;

   smem_token_store #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
      .store_valid_curr_i(store_valid_curr),
      .curr_x_0_i(curr_x_0), .curr_x_1_i(curr_x_1), .curr_x_2_i(curr_x_2),
      .curr_x_info_i(curr_x_info), .curr_x_addr_i(curr_x_addr),
      .store_valid_mem_i(store_valid_mem),
      .mem_x_0_i(mem_x_0), .mem_x_1_i(mem_x_1), .mem_x_2_i(mem_x_2),
      .mem_x_info_i(mem_x_info), .mem_x_addr_i(mem_x_addr),
      .current_rd_addr_i(current_rd_addr), .rd_data_o(rd_data),
      .drain_start_i(drain_start), .drain_len_i(drain_len),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_idx_o(out_idx),
      .drain_busy_o(drain_busy), .drain_done_o(drain_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] mk(input logic [63:0] v);
      return {v + 64'd3, v + 64'd2, v + 64'd1, v};
   endfunction

   // Drive a curr write for one edge; caller is just after a negedge.
   task automatic wr_curr(input logic [ADDR_W-1:0] a, input logic [63:0] v);
      store_valid_curr = 1'b1; curr_x_addr = a;
      {curr_x_info, curr_x_2, curr_x_1, curr_x_0} = mk(v);
      @(negedge clk);
      store_valid_curr = 1'b0;
   endtask

   task automatic wr_mem(input logic [ADDR_W-1:0] a, input logic [63:0] v);
      store_valid_mem = 1'b1; mem_x_addr = a;
      {mem_x_info, mem_x_2, mem_x_1, mem_x_0} = mk(v);
      @(negedge clk);
      store_valid_mem = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      nchk++; if (rd_data !== 256'd0) begin nfail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
      nchk++; if (out_data !== 256'd0) begin nfail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      nchk++; if (out_idx !== '0) begin nfail++; $display("FAIL reset_out_idx got %0d exp 0", out_idx); end
      nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      nchk++; if (drain_busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b exp 0", drain_busy); end
      nchk++; if (drain_done !== 1'b0) begin nfail++; $display("FAIL reset_done got %b exp 0", drain_done); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_curr_read;
      current_rd_addr = 7'd0;
      wr_curr(7'd5, 64'd1);
      current_rd_addr = 7'd5;
      @(negedge clk);
      nchk++; if (rd_data !== mk(64'd1)) begin nfail++; $display("FAIL curr_read got %h exp %h", rd_data, mk(64'd1)); end
   endtask

   task automatic test_stall;
      wr_curr(7'd7, 64'd20);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         current_rd_addr = (i == 1) ? 7'd6 : 7'd7;
         @(negedge clk);
         nchk++; if (rd_data !== mk(64'd1)) begin nfail++; $display("FAIL stall_hold%0d got %h exp %h", i, rd_data, mk(64'd1)); end
      end
      stall = 1'b0;
      @(negedge clk);
      nchk++; if (rd_data !== mk(64'd20)) begin nfail++; $display("FAIL stall_release got %h exp %h", rd_data, mk(64'd20)); end
   endtask

   task automatic test_collision;
      logic [255:0] exp_col;
`ifdef TOKEN_STORE_BYPASS_EN
      exp_col = mk(64'd200);
`else
      exp_col = mk(64'd100);
`endif
      current_rd_addr = 7'd5;
      wr_curr(7'd9, 64'd100);
      current_rd_addr = 7'd9;
      wr_curr(7'd9, 64'd200);
      nchk++; if (rd_data !== exp_col) begin nfail++; $display("FAIL collision got %h exp %h", rd_data, exp_col); end
      @(negedge clk);
      nchk++; if (rd_data !== mk(64'd200)) begin nfail++; $display("FAIL post_collision got %h exp %h", rd_data, mk(64'd200)); end
   endtask

   task automatic test_drain;
      wr_mem(7'd0, 64'd10);
      wr_mem(7'd1, 64'd11);
      wr_mem(7'd2, 64'd12);
      out_ready = 1'b0;
      drain_start = 1'b1; drain_len = 8'd3;
      @(negedge clk);
      drain_start = 1'b0;
      nchk++; if (out_valid !== 1'b0 || drain_busy !== 1'b1) begin nfail++; $display("FAIL drain_fetch0 got v=%b busy=%b exp v=0 busy=1", out_valid, drain_busy); end
      @(negedge clk);
      nchk++; if (out_valid !== 1'b1 || out_idx !== 7'd0) begin nfail++; $display("FAIL drain_present0 got v=%b idx=%0d exp v=1 idx=0", out_valid, out_idx); end
      nchk++; if (out_data !== mk(64'd10)) begin nfail++; $display("FAIL drain_data0 got %h exp %h", out_data, mk(64'd10)); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL drain_fetch1 got v=%b exp 0", out_valid); end
      drain_start = 1'b1; drain_len = 8'd0;
      @(negedge clk);
      drain_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nchk++; if (out_valid !== 1'b1 || out_idx !== 7'd1 || out_data !== mk(64'd11)) begin
            nfail++; $display("FAIL drain_hold1_%0d got v=%b idx=%0d data=%h exp v=1 idx=1 data=%h", i, out_valid, out_idx, out_data, mk(64'd11));
         end
         nchk++; if (drain_done !== 1'b0) begin nfail++; $display("FAIL drain_ignored_start%0d got done=%b exp 0", i, drain_done); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      nchk++; if (out_valid !== 1'b1 || out_idx !== 7'd2 || out_data !== mk(64'd12)) begin
         nfail++; $display("FAIL drain_present2 got v=%b idx=%0d data=%h exp v=1 idx=2 data=%h", out_valid, out_idx, out_data, mk(64'd12));
      end
      @(negedge clk);
      out_ready = 1'b0;
      nchk++; if (drain_done !== 1'b1 || drain_busy !== 1'b1 || out_valid !== 1'b0) begin
         nfail++; $display("FAIL drain_done_pulse got done=%b busy=%b v=%b exp 1 1 0", drain_done, drain_busy, out_valid);
      end
      @(negedge clk);
      nchk++; if (drain_done !== 1'b0 || drain_busy !== 1'b0) begin
         nfail++; $display("FAIL drain_idle got done=%b busy=%b exp 0 0", drain_done, drain_busy);
      end
   endtask

   task automatic test_len_zero;
      drain_start = 1'b1; drain_len = 8'd0;
      @(negedge clk);
      drain_start = 1'b0;
      nchk++; if (drain_done !== 1'b1 || out_valid !== 1'b0) begin nfail++; $display("FAIL len0_done got done=%b v=%b exp 1 0", drain_done, out_valid); end
      @(negedge clk);
      nchk++; if (drain_done !== 1'b0 || drain_busy !== 1'b0 || out_valid !== 1'b0) begin
         nfail++; $display("FAIL len0_idle got done=%b busy=%b v=%b exp 0 0 0", drain_done, drain_busy, out_valid);
      end
   endtask

   task automatic test_full_depth;
      int cnt;
      bit seen;
      cnt = 0; seen = 1'b0;
      out_ready = 1'b1;
      drain_start = 1'b1; drain_len = 8'(DEPTH);
      @(negedge clk);
      drain_start = 1'b0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(negedge clk);
         if (drain_done) seen = 1'b1;
         if (out_valid) begin
            nchk++; if (out_idx !== 7'(cnt)) begin nfail++; $display("FAIL full_idx got %0d exp %0d", out_idx, cnt); end
            cnt++;
         end
      end
      nchk++; if (!seen) begin nfail++; $display("FAIL full_done_timeout got no drain_done exp pulse"); end
      nchk++; if (cnt !== DEPTH) begin nfail++; $display("FAIL full_count got %0d exp %0d", cnt, DEPTH); end
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      drain_start = 1'b1; drain_len = 8'd3;
      @(negedge clk);
      drain_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      nchk++; if (out_valid !== 1'b1 || out_idx !== 7'd1) begin nfail++; $display("FAIL rstmid_pre got v=%b idx=%0d exp 1 1", out_valid, out_idx); end
      rst_n = 1'b0;
      #1;
      nchk++; if (out_valid !== 1'b0 || drain_busy !== 1'b0 || drain_done !== 1'b0) begin
         nfail++; $display("FAIL rstmid_async got v=%b busy=%b done=%b exp 0 0 0", out_valid, drain_busy, drain_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      nchk++; if (drain_done !== 1'b0 || drain_busy !== 1'b0) begin nfail++; $display("FAIL rstmid_idle got done=%b busy=%b exp 0 0", drain_done, drain_busy); end
      out_ready = 1'b1;
      drain_start = 1'b1; drain_len = 8'd2;
      @(negedge clk);
      drain_start = 1'b0;
      @(negedge clk);
      nchk++; if (out_valid !== 1'b1 || out_idx !== 7'd0 || out_data !== mk(64'd10)) begin
         nfail++; $display("FAIL rstmid_data0 got v=%b idx=%0d data=%h exp %h", out_valid, out_idx, out_data, mk(64'd10));
      end
      @(negedge clk);
      @(negedge clk);
      nchk++; if (out_valid !== 1'b1 || out_idx !== 7'd1 || out_data !== mk(64'd11)) begin
         nfail++; $display("FAIL rstmid_data1 got v=%b idx=%0d data=%h exp %h", out_valid, out_idx, out_data, mk(64'd11));
      end
      @(negedge clk);
      nchk++; if (drain_done !== 1'b1) begin nfail++; $display("FAIL rstmid_done got %b exp 1", drain_done); end
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0;
      store_valid_curr = 1'b0; store_valid_mem = 1'b0;
      curr_x_0 = '0; curr_x_1 = '0; curr_x_2 = '0; curr_x_info = '0; curr_x_addr = '0;
      mem_x_0 = '0; mem_x_1 = '0; mem_x_2 = '0; mem_x_info = '0; mem_x_addr = '0;
      current_rd_addr = '0; drain_start = 1'b0; drain_len = '0; out_ready = 1'b0;
      test_reset;
      test_curr_read;
      test_stall;
      test_collision;
      test_drain;
      test_len_zero;
      test_full_depth;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
